// File: rtl/multi_key_filter_pkg.sv
// multi_key_filter_pkg: shared FSM states, event-type codes and width helper
package multi_key_filter_pkg;
  typedef enum logic [1:0] {UP, DEB_DN, DN, DEB_UP} key_st_e;
  localparam logic EVT_PRESS = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_key_filter_if.sv
// multi_key_filter_if: event port with valid/ack handshake and sticky overflow
interface multi_key_filter_if #(parameter int CH = 4);
  localparam int CW = multi_key_filter_pkg::ch_w(CH);
  logic evt_valid;
  logic [CW-1:0] evt_ch;
  logic evt_type;
  logic evt_ack;
  logic evt_ovf;
  modport master(output evt_valid, evt_ch, evt_type, evt_ovf, input evt_ack);
  modport slave(input evt_valid, evt_ch, evt_type, evt_ovf, output evt_ack);
endinterface

// File: rtl/key_filter_ch.sv
// key_filter_ch: one key's 2-flop synchroniser, debounce FSM and stable-cycle counter
module key_filter_ch import multi_key_filter_pkg::*; #(
  parameter int CNT_MAX = 1_000_000,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic press_set,
  output logic release_set
);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MAX = CW'(CNT_MAX);
  localparam logic [CW-1:0] ONE = CW'(1);
  key_st_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] sync;
  logic s, done;
  assign s = sync[1] ^ ACTIVE_LOW;
  assign done = cnt == MAX;
  assign key_state = st == DN || st == DEB_UP;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      sync <= {2{ACTIVE_LOW}};
      st <= UP;
      cnt <= '0;
      key_press <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync <= {sync[0], key};
      st <= st_n;
      cnt <= cnt_n;
      key_press <= press_set;
      key_release <= release_set;
    end
  // a level is accepted once the counter has seen CNT_MAX further agreeing samples
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    press_set = 1'b0;
    release_set = 1'b0;
    case (st)
      UP: if (s) begin st_n = DEB_DN; cnt_n = ONE; end
      DEB_DN:
        if (!s) begin st_n = UP; cnt_n = '0; end
        else if (done) begin st_n = DN; cnt_n = '0; press_set = 1'b1; end
        else cnt_n = cnt + ONE;
      DN: if (!s) begin st_n = DEB_UP; cnt_n = ONE; end
      DEB_UP:
        if (s) begin st_n = DN; cnt_n = '0; end
        else if (done) begin st_n = UP; cnt_n = '0; release_set = 1'b1; end
        else cnt_n = cnt + ONE;
      default: st_n = UP;
    endcase
  end
endmodule

// File: rtl/multi_key_filter.sv
// multi_key_filter: CH debounced keys feeding a lowest-channel-first event port
module multi_key_filter import multi_key_filter_pkg::*; #(
  parameter int CH = 4,
  parameter int CNT_MAX = 1_000_000,
  parameter bit ACTIVE_LOW = 1,
  parameter bit REPORT_RELEASE = 0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic [CH-1:0] key_in,
  output logic [CH-1:0] key_state,
  output logic [CH-1:0] key_press,
  output logic [CH-1:0] key_release,
  multi_key_filter_if.master evt
);
  localparam int CW = ch_w(CH);
  logic [CH-1:0] press_set, release_set, pend, typ, pend_n, typ_n, clr;
  logic [CW-1:0] ch_n;
  logic ovf_n;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    key_filter_ch #(.CNT_MAX(CNT_MAX), .ACTIVE_LOW(ACTIVE_LOW)) u_ch (
      .Clk(Clk),
      .Reset(Reset),
      .key(key_in[i]),
      .key_state(key_state[i]),
      .key_press(key_press[i]),
      .key_release(key_release[i]),
      .press_set(press_set[i]),
      .release_set(release_set[i])
    );
  end
  // outputs are registered from next-state pending so they rise with the key pulse
  always_comb begin
    clr = '0;
    if (evt.evt_valid && evt.evt_ack) clr[evt.evt_ch] = 1'b1;
    pend_n = pend & ~clr;
    typ_n = typ;
    ovf_n = evt.evt_ovf;
    ch_n = '0;
    for (int c = 0; c < CH; c++)
      if (press_set[c] || (REPORT_RELEASE && release_set[c])) begin
        pend_n[c] = 1'b1;
        typ_n[c] = press_set[c] ? EVT_PRESS : EVT_RELEASE;
        ovf_n = ovf_n | (pend[c] & ~clr[c]);
      end
    for (int c = CH - 1; c >= 0; c--)
      if (pend_n[c]) ch_n = CW'(c);
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      pend <= '0;
      typ <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_ch <= '0;
      evt.evt_type <= 1'b0;
      evt.evt_ovf <= 1'b0;
    end else begin
      pend <= pend_n;
      typ <= typ_n;
      evt.evt_valid <= |pend_n;
      evt.evt_ch <= ch_n;
      evt.evt_type <= |pend_n & typ_n[ch_n];
      evt.evt_ovf <= ovf_n;
    end
endmodule

// File: tb/tb_multi_key_filter.sv
// tb_multi_key_filter: vector table, corner sequences and random run against a window model
module tb_multi_key_filter;
  import multi_key_filter_pkg::*;
  localparam int CH = 4;
  localparam int CNT_MAX = 4;
  localparam int NH = CNT_MAX + 3;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [CH-1:0] key_in = '1;
  logic [CH-1:0] key_state, key_press, key_release;
  multi_key_filter_if #(.CH(CH)) evt();
  multi_key_filter #(.CH(CH), .CNT_MAX(CNT_MAX), .ACTIVE_LOW(1), .REPORT_RELEASE(1)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .key_in(key_in),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .evt(evt)
  );
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  bit hist [CH][NH];
  bit [CH-1:0] m_lvl, m_press, m_rel, m_pend, m_typ;
  bit m_ovf;

  typedef struct {
    logic [3:0] key;
    logic ack;
    logic [16:0] exp;
  } vec_t;
  vec_t tv [18];

  function automatic logic [16:0] mk(input logic [3:0] st, input logic [3:0] pr, input logic v,
                                     input logic [1:0] ch, input logic ty);
    return {st, pr, 4'h0, v, ch, ty, 1'b0};
  endfunction

  function automatic int lowest(input bit [CH-1:0] p);
    for (int i = 0; i < CH; i++) if (p[i]) return i;
    return 0;
  endfunction

  function automatic logic [16:0] act_v();
    return {key_state, key_press, key_release, evt.evt_valid, evt.evt_ch, evt.evt_type, evt.evt_ovf};
  endfunction

  function automatic logic [16:0] m_exp();
    int l = lowest(m_pend);
    return {m_lvl, m_press, m_rel, |m_pend, 2'(l), |m_pend ? m_typ[l] : 1'b0, m_ovf};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // event channel/type are don't-care while nothing is pending
  task automatic chk_v(input string nm, input logic [16:0] a, input logic [16:0] e);
    if (!e[4]) begin
      a[3:1] = '0;
      e[3:1] = '0;
    end
    chk(nm, 32'(a), 32'(e));
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) for (int k = 0; k < NH; k++) hist[c][k] = 1'b0;
    m_lvl = '0; m_press = '0; m_rel = '0; m_pend = '0; m_typ = '0; m_ovf = 1'b0;
  endtask

  // a level flips once the synchronised input has disagreed with it for CNT_MAX+1 samples
  task automatic model_edge();
    bit [CH-1:0] clr = '0;
    bit flip;
    if (evt.evt_ack && |m_pend) clr[lowest(m_pend)] = 1'b1;
    m_pend &= ~clr;
    m_press = '0;
    m_rel = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = NH - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = ~key_in[c];
      flip = 1'b1;
      for (int k = 2; k < NH; k++) if (hist[c][k] == m_lvl[c]) flip = 1'b0;
      if (flip) begin
        m_lvl[c] = ~m_lvl[c];
        m_press[c] = m_lvl[c];
        m_rel[c] = ~m_lvl[c];
        if (m_pend[c]) m_ovf = 1'b1;
        m_pend[c] = 1'b1;
        m_typ[c] = m_lvl[c];
      end
    end
  endtask

  task automatic step(input string nm);
    @(posedge Clk);
    model_edge();
    #1;
    chk_v(nm, act_v(), m_exp());
  endtask

  task automatic pulse_reset();
    #2 Reset = 1'b1;
    #1;
    model_reset();
    #2 Reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && evt.evt_valid; i++) begin
      evt.evt_ack = 1'b1;
      step("drain");
    end
    evt.evt_ack = 1'b0;
    chk("drain_done", 32'(evt.evt_valid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, at;
    evt.evt_ack = 1'b0;
    model_reset();
    #12;
    chk("reset", 32'(act_v()), 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) tv[i] = '{4'hE, 1'b0, mk(4'h0, 4'h0, 1'b0, 2'd0, 1'b0)};
    tv[6] = '{4'hE, 1'b0, mk(4'h1, 4'h1, 1'b1, 2'd0, 1'b1)};
    tv[7] = '{4'hE, 1'b1, mk(4'h1, 4'h0, 1'b0, 2'd0, 1'b0)};
    for (int i = 8; i < 14; i++) tv[i] = '{4'h8, 1'b0, mk(4'h1, 4'h0, 1'b0, 2'd0, 1'b0)};
    tv[14] = '{4'h8, 1'b0, mk(4'h7, 4'h6, 1'b1, 2'd1, 1'b1)};
    tv[15] = '{4'h8, 1'b1, mk(4'h7, 4'h0, 1'b1, 2'd2, 1'b1)};
    tv[16] = '{4'h8, 1'b1, mk(4'h7, 4'h0, 1'b0, 2'd0, 1'b0)};
    tv[17] = '{4'h8, 1'b1, mk(4'h7, 4'h0, 1'b0, 2'd0, 1'b0)};
    for (int i = 0; i < 18; i++) begin
      key_in = tv[i].key;
      evt.evt_ack = tv[i].ack;
      step("vec_model");
      chk_v($sformatf("vec%0d", i), act_v(), tv[i].exp);
    end
    evt.evt_ack = 1'b0;

    key_in[3] = 1'b0;
    repeat (3) step("bounce");
    key_in[3] = 1'b1;
    step("bounce");
    key_in[3] = 1'b0;
    cnt = 0; at = 0;
    for (int j = 1; j <= 15; j++) begin
      step("bounce");
      if (key_press[3]) begin cnt++; at = j; end
    end
    chk("bounce_count", 32'(cnt), 32'd1);
    chk("bounce_time", 32'(at), 32'(CNT_MAX + 3));
    drain();

    key_in = '1;
    pulse_reset();
    key_in[0] = 1'b0;
    repeat (CNT_MAX + 3) step("ovf_press");
    chk("ovf_press_pulse", 32'(key_press), 32'd1);
    repeat (2) step("ovf_hold");
    key_in[0] = 1'b1;
    repeat (CNT_MAX + 3) step("ovf_rel");
    chk("ovf_valid", 32'(evt.evt_valid), 32'd1);
    chk("ovf_type", 32'(evt.evt_type), 32'(EVT_RELEASE));
    chk("ovf_flag", 32'(evt.evt_ovf), 32'd1);

    key_in[0] = 1'b0;
    repeat (3) step("midfilt");
    #2 Reset = 1'b1;
    #1;
    chk("rst_async", 32'(act_v()), 32'd0);
    model_reset();
    #2 Reset = 1'b0;
    at = 0;
    for (int j = 1; j <= CNT_MAX + 4; j++) begin
      step("rst_refilter");
      if (key_press[0] && at == 0) at = j;
    end
    chk("rst_refilter_time", 32'(at), 32'(CNT_MAX + 3));

    key_in[0] = 1'b1;
    repeat (CNT_MAX + 2) step("ack_coinc");
    evt.evt_ack = 1'b1;
    step("ack_coinc");
    evt.evt_ack = 1'b0;
    chk("coinc_pulse", 32'(key_release), 32'd1);
    chk("coinc_valid", 32'(evt.evt_valid), 32'd1);
    chk("coinc_type", 32'(evt.evt_type), 32'(EVT_RELEASE));
    chk("coinc_ovf", 32'(evt.evt_ovf), 32'd0);
    drain();

    repeat (3000) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(7) == 0) key_in[c] = ~key_in[c];
      evt.evt_ack = 1'($urandom_range(1));
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_key_filter.md
# multi_key_filter

Parametrised multi-channel push-button conditioner between raw board inputs and control logic. Each of `CH` channels is synchronised, debounced by a per-channel state machine, and turned into a clean level plus one-cycle press and release pulses. A shared event port reports per-channel events with a valid/ack handshake. Events are reported lowest channel first, and an overflow flag records lost events.

## Interface
- `CH`, 4: number of input channels (1..16).
- `CNT_MAX`, 1_000_000: number of consecutive stable cycles required to accept a new level (20 ms at 50 MHz); minimum 1.
- `ACTIVE_LOW`, 1: 1 means a key reads 0 when pressed; 0 means it reads 1 when pressed.
- `REPORT_RELEASE`, 0: 1 means release events are also queued on the event port.

- `Clk`  in  1  system clock; all logic on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `key_in`  in  CH  raw asynchronous key inputs.
- `key_state`  out  CH  debounced level per channel; 1 means pressed.
- `key_press`  out  CH  one-cycle pulse on an accepted press.
- `key_release`  out  CH  one-cycle pulse on an accepted release.
- `evt_valid`  out  1  at least one channel has a pending event.
- `evt_ch`  out  $clog2(CH) or 1, whichever is larger  index of the lowest pending channel.
- `evt_type`  out  1  type of that channel's event; 1 is press, 0 is release.
- `evt_ack`  in  1  consumer accepts the presented event.
- `evt_ovf`  out  1  sticky flag: a pending event was overwritten. Cleared only by reset.

## Operation
- Per channel, a 2-flop synchroniser feeds a normalised level `s`, with `ACTIVE_LOW` applied (`s`=1 means pressed).
- Per-channel FSM states:
  - UP: stable released.
  - DEB_DN: filtering toward pressed.
  - DN: stable pressed.
  - DEB_UP: filtering toward released.
- FSM transitions:
  - UP with `s`=1 → DEB_DN, count=1.
  - DEB_DN with `s`=1 → count+1; when count reaches `CNT_MAX`, go to DN and pulse `key_press`.
  - DEB_DN with `s`=0 → UP, count=0, no pulse. This is the bounce-reject case.
  - DN and DEB_UP are symmetric, pulsing `key_release`.
- Counter width is $clog2(CNT_MAX+1). The counter never exceeds `CNT_MAX` and never wraps.
- `key_state` = 1 in DN and DEB_UP; 0 in UP and DEB_DN.
- Event queue:
  - Each channel has a pending bit and a type bit.
  - An accepted press, or an accepted release when `REPORT_RELEASE`=1, sets pending and writes type.
  - If pending was already set and is not being acked that cycle, the type is overwritten and `evt_ovf` is set.
- Handshake:
  - `evt_valid` = OR of pending bits; `evt_ch` and `evt_type` come from the lowest set index.
  - `evt_ack` while `evt_valid` is high clears that channel's pending bit at the next edge.
  - `evt_ack` while `evt_valid` is low is ignored.
- Simultaneous events:
  - A new event and an ack on the same channel in the same cycle leave pending set with the new type, and `evt_ovf` is not set.
  - Events on different channels in the same cycle are all recorded.

## Timing
- Reset values:
  - Synchronisers hold the released level.
  - All FSMs are in UP with count=0.
  - `key_state`, `key_press`, `key_release`, pending bits, `evt_valid`, `evt_ovf`, `evt_type` and `evt_ch` are all 0.
- Latency: if `key_in` changes before edge E and holds, `key_press`/`key_release` is high during the cycle after edge E+`CNT_MAX`+2. `key_state` changes on the same edge.
- `evt_valid` rises on the same edge as the pulse; all event outputs are registered.
- Ack to next event: the next pending channel is presented one cycle after the ack edge.
- Reset asserted mid-filter or mid-handshake: everything returns to reset values immediately; no pulse is emitted.
- A glitch shorter than `CNT_MAX` cycles never produces a pulse.

## Structure
- Package `multi_key_filter_pkg` holds the FSM state enum (UP, DEB_DN, DN, DEB_UP) and the event-type constants `EVT_PRESS`=1 and `EVT_RELEASE`=0.
- Sub-module `key_filter_ch` contains one channel's synchroniser, FSM and counter. It is instantiated `CH` times with a generate loop.
- The top level contains the pending/type registers, priority encoder and overflow flag.

## Test plan
Bench configuration: `CH`=4, `CNT_MAX`=4, `ACTIVE_LOW`=1.
- Clean press: drive `key_in`[0] low and hold → `key_press`[0] pulses exactly 1 cycle after edge E+6; `evt_valid`=1, `evt_ch`=0, `evt_type`=1; `key_state`[0]=1.
- Bounce: `key_in`[3] low for 3 cycles, high for 1, then low and held → exactly one `key_press`[3], timed from the final falling level.
- Priority and ack: press ch2 and ch1 in the same cycle → `evt_ch`=1 first; ack → `evt_ch`=2 one cycle later; second ack → `evt_valid`=0.
- Overflow: `REPORT_RELEASE`=1, press and release ch0 without ack → `evt_type`=0 and `evt_ovf`=1. Repeat with an ack coinciding with the release pulse → `evt_ovf` stays 0.
- Reset mid-filter: assert `Reset` while ch0 is in DEB_DN → all outputs 0 asynchronously; after release, a held-low key needs the full `CNT_MAX`+2 cycles again.
